// File: rtl/netbus_frame_reader.sv
// netbus_frame_reader: pops whole frames from the NetBus read FIFO and forwards them through a
// 2-entry skid buffer, truncating over-long frames and counting completed frames.
`default_nettype none

module netbus_frame_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_FLITS  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [DATA_WIDTH*9+13:0]  FDATA,
    input  logic                      FVALID,
    output logic                      FREADY,
    input  logic                      FFRAME,
    output logic [DATA_WIDTH*9+13:0]  MDATA,
    output logic                      MVALID,
    input  logic                      MREADY,
    output logic [CNT_WIDTH-1:0]      FRAME_CNT,
    output logic                      LEN_ERR
);

    localparam int W     = DATA_WIDTH * 9 + 14;
    localparam int LEN_W = $clog2(MAX_FLITS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 out_vld_q, out_vld_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [W-1:0]         skid_data_q, skid_data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 len_err_q, len_err_d;

    logic                 fready;
    logic                 push;
    logic                 xfer;
    logic [W-1:0]         push_data;

    // Pop strobe depends only on state and skid occupancy, never on MREADY/FVALID.
    always_comb begin
        fready = 1'b0;
        case (state_q)
            S_STREAM:  fready = !skid_vld_q;
            S_DISCARD: fready = 1'b1;
            default:   fready = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        push      = 1'b0;
        push_data = FDATA;
        len_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (FFRAME && FVALID) begin
                    state_d = S_STREAM;
                    len_d   = '0;
                end
            end
            S_STREAM: begin
                if (fready && FVALID) begin
                    push  = 1'b1;
                    len_d = len_q + LEN_W'(1);
                    if (FDATA[0]) begin
                        state_d = S_IDLE;
                    end else if (len_q == LEN_W'(MAX_FLITS - 1)) begin
                        // Last permitted flit of an over-long frame becomes its EOF.
                        push_data[0] = 1'b1;
                        len_err_d    = 1'b1;
                        state_d      = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (FVALID && FDATA[0]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign xfer = out_vld_q && MREADY;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (!out_vld_q || xfer) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                skid_vld_d = push;
                if (push) begin
                    skid_data_d = push_data;
                end
            end else begin
                out_vld_d = push;
                if (push) begin
                    out_data_d = push_data;
                end
            end
        end else if (push) begin
            skid_vld_d  = 1'b1;
            skid_data_d = push_data;
        end
    end

    assign cnt_d = cnt_q + ((xfer && out_data_q[0]) ? CNT_WIDTH'(1) : CNT_WIDTH'(0));

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            cnt_q       <= cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign FREADY    = fready;
    assign MDATA     = out_data_q;
    assign MVALID    = out_vld_q;
    assign FRAME_CNT = cnt_q;
    assign LEN_ERR   = len_err_q;

endmodule

`default_nettype wire
